// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives enable/flush of every inter-stage register.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FILL_CYCLES     = 4,
    parameter int REDIRECT_CYCLES = 1,
    parameter int REG_ADDR_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_branch_taken,
    input  logic                  i_ex_busy,
    input  logic                  i_mem_stall_req,
    output logic                  o_pc_en,
    output logic                  o_if_id_en,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_en,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_en,
    output logic                  o_ex_mem_flush,
    output logic                  o_mem_wb_en,
    output logic                  o_mem_wb_flush,
    output logic [31:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_flush_cnt
);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_REDIRECT
    } state_t;

    localparam logic [3:0] LP_FILL_LAST    = 4'(FILL_CYCLES - 1);
    localparam logic [2:0] LP_REDIR_LOAD   = 3'(REDIRECT_CYCLES - 1);
    localparam bit         LP_REDIR_MULTI  = (REDIRECT_CYCLES > 1);

    state_t     r_state;
    logic [3:0] r_fill_cnt;
    logic [2:0] r_redir_cnt;
    logic       w_load_use;
    logic       w_hold;

    // A load to x0 never produces a value, so it can never create a hazard.
    assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
    assign w_hold     = i_mem_stall_req || i_ex_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_fill_cnt  <= '0;
            r_redir_cnt <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (r_fill_cnt == LP_FILL_LAST) begin
                        r_state    <= S_RUN;
                        r_fill_cnt <= '0;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    if (!w_hold && i_ex_branch_taken && LP_REDIR_MULTI) begin
                        r_state     <= S_REDIRECT;
                        r_redir_cnt <= LP_REDIR_LOAD;
                    end
                end
                S_REDIRECT: begin
                    // Stalls freeze the redirect window; a fresh branch restarts it.
                    if (!w_hold) begin
                        if (i_ex_branch_taken) begin
                            r_redir_cnt <= LP_REDIR_LOAD;
                        end else if (r_redir_cnt <= 3'd1) begin
                            r_state     <= S_RUN;
                            r_redir_cnt <= '0;
                        end else begin
                            r_redir_cnt <= r_redir_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    always_comb begin
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_ex_mem_flush = 1'b0;
        o_mem_wb_en    = 1'b1;
        o_mem_wb_flush = 1'b0;
        if (r_state == S_FILL) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_en     = 1'b0;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_en    = 1'b0;
            o_ex_mem_flush = 1'b1;
            o_mem_wb_en    = 1'b0;
            o_mem_wb_flush = 1'b1;
        end else if (i_mem_stall_req) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_flush = 1'b1;
        end else if (i_ex_busy) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_flush = 1'b1;
        end else if (i_ex_branch_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end else begin
            if (r_state == S_REDIRECT) begin
                o_if_id_flush = 1'b1;
            end
            if (w_load_use) begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Fill cycles are excluded: they are start-up bubbles, not lost throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state != S_FILL) begin
            if (!o_pc_en) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (o_if_id_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_stall_cnt = r_stall_cnt;
    assign o_perf_flush_cnt = r_flush_cnt;
`else
    assign o_perf_stall_cnt = 32'd0;
    assign o_perf_flush_cnt = 32'd0;
`endif

endmodule
